// File: rtl/tlp_send.sv
`default_nettype none
// ============================================================================
// Module   : tlp_send (with tlp_xcvr_pkg)
// Purpose  : Transmit half of tlp-xcvr. Turns action words into register
//            writes, or into register reads answered by a 3DW CplD TLP.
// Revision : 1.0  initial release
// ============================================================================

package tlp_xcvr_pkg;
    typedef logic [3:0] ExtChan;
    typedef enum logic {ACT_WRITE = 1'b0, ACT_READ = 1'b1} ActKind;

    // Action word layout: {kind, chan, reqID, tag, data}
    typedef logic [60:0] Action;

    function automatic ActKind actKind(input Action a);
        return ActKind'(a[60]);
    endfunction
    function automatic ExtChan actChan(input Action a);
        return a[59:56];
    endfunction
    function automatic logic [15:0] actReqID(input Action a);
        return a[55:40];
    endfunction
    function automatic logic [7:0] actTag(input Action a);
        return a[39:32];
    endfunction
    function automatic logic [31:0] actData(input Action a);
        return a[31:0];
    endfunction
    function automatic Action makeAction(input ActKind k, input ExtChan c,
                                         input logic [15:0] r, input logic [7:0] t,
                                         input logic [31:0] d);
        return {k, c, r, t, d};
    endfunction
endpackage

module tlp_send
    import tlp_xcvr_pkg::*;
#(
    parameter int unsigned RD_TIMEOUT = 255
) (
    input  logic          pcieClk_in,
    input  logic          pcieRst_in,
    input  logic [15:0]   cfgBusID_in,
    input  Action         actData_in,
    input  logic          actValid_in,
    output logic          actReady_out,
    output logic [63:0]   txData_out,
    output logic          txValid_out,
    input  logic          txReady_in,
    output logic          txSOP_out,
    output logic          txEOP_out,
    output ExtChan        regRdChan_out,
    output logic          regRdReq_out,
    input  logic [63:0]   regRdData_in,
    input  logic          regRdValid_in,
    output ExtChan        regWrChan_out,
    output logic [31:0]   regWrData_out,
    output logic          regWrValid_out,
    output logic          rdTimeout_out
);
    localparam logic [31:0] c_DW0     = 32'h4A00_0002;
    localparam logic [15:0] c_TIMEOUT = 16'(RD_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_WAIT = 3'd1,
        S_CPL0    = 3'd2,
        S_CPL1    = 3'd3,
        S_CPL2    = 3'd4
    } state_t;

    state_t        r_state;
    logic [15:0]   r_cnt;
    logic [15:0]   r_reqID;
    logic [7:0]    r_tag;
    logic [15:0]   r_busID;
    ExtChan        r_rdChan;
    logic [63:0]   r_rdData;
    logic [63:0]   r_txData;
    logic          r_txValid;
    logic          r_txSOP;
    logic          r_txEOP;
    logic          r_rdReq;
    logic          r_rdTimeout;
    ExtChan        r_wrChan;
    logic [31:0]   r_wrData;
    logic          r_wrValid;
    logic          w_accept;

    // Ready is forced low while reset is held, not just after the first edge.
    assign actReady_out = (r_state == S_IDLE) && !pcieRst_in;
    assign w_accept     = actValid_in && actReady_out;

    always_ff @(posedge pcieClk_in or posedge pcieRst_in) begin
        if (pcieRst_in) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_reqID     <= '0;
            r_tag       <= '0;
            r_busID     <= '0;
            r_rdChan    <= '0;
            r_rdData    <= '0;
            r_txData    <= '0;
            r_txValid   <= 1'b0;
            r_txSOP     <= 1'b0;
            r_txEOP     <= 1'b0;
            r_rdReq     <= 1'b0;
            r_rdTimeout <= 1'b0;
            r_wrChan    <= '0;
            r_wrData    <= '0;
            r_wrValid   <= 1'b0;
        end else begin
            r_wrValid   <= 1'b0;
            r_rdReq     <= 1'b0;
            r_rdTimeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (actKind(actData_in) == ACT_WRITE) begin
                            r_wrValid <= 1'b1;
                            r_wrChan  <= actChan(actData_in);
                            r_wrData  <= actData(actData_in);
                        end else begin
                            r_reqID  <= actReqID(actData_in);
                            r_tag    <= actTag(actData_in);
                            r_rdChan <= actChan(actData_in);
                            r_busID  <= cfgBusID_in;
                            r_rdReq  <= 1'b1;
                            r_cnt    <= '0;
                            r_state  <= S_RD_WAIT;
                        end
                    end
                end
                S_RD_WAIT: begin
                    // Real data beats a timeout landing in the same cycle.
                    if (regRdValid_in || (r_cnt == c_TIMEOUT)) begin
                        r_rdData    <= regRdValid_in ? regRdData_in : '1;
                        r_rdTimeout <= !regRdValid_in;
                        r_txData    <= {r_busID, 3'b000, 1'b0, 12'd8, c_DW0};
                        r_txValid   <= 1'b1;
                        r_txSOP     <= 1'b1;
                        r_state     <= S_CPL0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_CPL0: begin
                    if (txReady_in) begin
                        r_txData <= {32'h0, r_reqID, r_tag, 1'b0, r_rdChan[3:0], 3'b000};
                        r_txSOP  <= 1'b0;
                        r_state  <= S_CPL1;
                    end
                end
                S_CPL1: begin
                    if (txReady_in) begin
                        r_txData <= r_rdData;
                        r_txEOP  <= 1'b1;
                        r_state  <= S_CPL2;
                    end
                end
                S_CPL2: begin
                    if (txReady_in) begin
                        r_txValid <= 1'b0;
                        r_txEOP   <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign txData_out     = r_txData;
    assign txValid_out    = r_txValid;
    assign txSOP_out      = r_txSOP;
    assign txEOP_out      = r_txEOP;
    assign regRdChan_out  = r_rdChan;
    assign regRdReq_out   = r_rdReq;
    assign regWrChan_out  = r_wrChan;
    assign regWrData_out  = r_wrData;
    assign regWrValid_out = r_wrValid;
    assign rdTimeout_out  = r_rdTimeout;
endmodule

`default_nettype wire

// File: tb/tb_tlp_send.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlp_send
// Purpose  : Directed, table-driven bench for tlp_send (RD_TIMEOUT = 4).
// Revision : 1.0  initial release
// ============================================================================
module tb_tlp_send;
    import tlp_xcvr_pkg::*;

    localparam int RDT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] busid = '0;
    Action       act = '0;
    logic        actValid = 1'b0;
    logic        actReady;
    logic [63:0] txData;
    logic        txValid;
    logic        txReady = 1'b0;
    logic        txSOP;
    logic        txEOP;
    ExtChan      rdChan;
    logic        rdReq;
    logic [63:0] rdData = '0;
    logic        rdValid = 1'b0;
    ExtChan      wrChan;
    logic [31:0] wrData;
    logic        wrValid;
    logic        tmo;

    int n_pass  = 0;
    int n_total = 0;

    tlp_send #(.RD_TIMEOUT(RDT)) dut (
        .pcieClk_in     (clk),
        .pcieRst_in     (rst),
        .cfgBusID_in    (busid),
        .actData_in     (act),
        .actValid_in    (actValid),
        .actReady_out   (actReady),
        .txData_out     (txData),
        .txValid_out    (txValid),
        .txReady_in     (txReady),
        .txSOP_out      (txSOP),
        .txEOP_out      (txEOP),
        .regRdChan_out  (rdChan),
        .regRdReq_out   (rdReq),
        .regRdData_in   (rdData),
        .regRdValid_in  (rdValid),
        .regWrChan_out  (wrChan),
        .regWrData_out  (wrData),
        .regWrValid_out (wrValid),
        .rdTimeout_out  (tmo)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200us, required finish");
        $fatal(1);
    end

    typedef struct {
        ExtChan      chan;
        logic [31:0] data;
        ExtChan      exp_chan;
        logic [31:0] exp_data;
    } wr_vec_t;

    typedef struct {
        ExtChan      chan;
        logic [15:0] reqid;
        logic [7:0]  tag;
        logic [15:0] bus;
        logic [63:0] data;
        int          delay;
        logic [63:0] b0;
        logic [63:0] b1;
        logic [63:0] b2;
    } rd_vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one READ, answer it (or not), drain the completion and check it.
    task automatic do_read(input rd_vec_t v, input bit give_data, input bit stall,
                           input bit hold, input Action nxt, input bit exp_tmo,
                           input string nm);
        int k = 0;
        int first_k = -1;
        int tmo_cnt = 0, wr_cnt = 0, req_cnt = 0, ar_viol = 0;
        int stab_viol = 0, stalls = 0, nb = 0;
        bit done = 1'b0;
        logic rdy = 1'b0;
        logic [63:0] beats [3];
        logic [2:0] sopv = '0, eopv = '0;
        logic pv = 1'b0, pr = 1'b0, ps = 1'b0, pe = 1'b0;
        logic [63:0] pd = '0;

        beats[0] = '0; beats[1] = '0; beats[2] = '0;
        busid    = v.bus;
        act      = makeAction(ACT_READ, v.chan, v.reqid, v.tag, 32'h0);
        actValid = 1'b1;
        check({nm, "_ready_idle"}, 64'(actReady), 64'd1);
        tick();
        actValid = hold;
        act      = nxt;
        busid    = 16'hFFFF;
        check({nm, "_rdreq"}, 64'(rdReq), 64'd1);
        check({nm, "_rdchan"}, 64'(rdChan), 64'(v.chan));
        while (!done && k < 40) begin
            if (give_data && k == v.delay) begin
                rdValid = 1'b1; rdData = v.data;
            end else if (give_data && k > v.delay) begin
                rdValid = 1'b1; rdData = 64'hBADB_ADBA_DBAD_BAD0;
            end else begin
                rdValid = 1'b0; rdData = v.data;
            end
            if (k > 0 && rdReq) req_cnt++;
            if (tmo) tmo_cnt++;
            if (wrValid) wr_cnt++;
            if (actReady) ar_viol++;
            rdy     = stall ? ~rdy : 1'b1;
            txReady = rdy;
            if (pv && !pr && (txValid !== 1'b1 || txData !== pd || txSOP !== ps || txEOP !== pe))
                stab_viol++;
            if (txValid && first_k < 0) first_k = k;
            if (txValid && !txReady) stalls++;
            if (txValid && txReady) begin
                if (nb < 3) begin
                    beats[nb] = txData; sopv[nb] = txSOP; eopv[nb] = txEOP;
                end
                nb++;
                if (txEOP) done = 1'b1;
            end
            pv = txValid; pr = txReady; pd = txData; ps = txSOP; pe = txEOP;
            tick();
            k++;
        end
        rdValid = 1'b0;
        txReady = 1'b0;
        check({nm, "_done"}, 64'(done), 64'd1);
        check({nm, "_nbeats"}, 64'(nb), 64'd3);
        check({nm, "_beat0"}, beats[0], v.b0);
        check({nm, "_beat1"}, beats[1], v.b1);
        check({nm, "_beat2"}, beats[2], v.b2);
        check({nm, "_sop"}, 64'(sopv), 64'b001);
        check({nm, "_eop"}, 64'(eopv), 64'b100);
        check({nm, "_tmo_pulses"}, 64'(tmo_cnt), 64'(exp_tmo));
        check({nm, "_first_beat_cycle"}, 64'(first_k), 64'(exp_tmo ? RDT + 1 : v.delay + 1));
        check({nm, "_extra_rdreq"}, 64'(req_cnt), 64'd0);
        check({nm, "_ready_busy"}, 64'(ar_viol), 64'd0);
        check({nm, "_wr_busy"}, 64'(wr_cnt), 64'd0);
        check({nm, "_stable"}, 64'(stab_viol), 64'd0);
        if (stall) check({nm, "_stalls_seen"}, 64'(stalls > 0), 64'd1);
        check({nm, "_ready_after"}, 64'(actReady), 64'd1);
        check({nm, "_txvalid_after"}, 64'(txValid), 64'd0);
    endtask

    initial begin
        wr_vec_t wv [4];
        rd_vec_t rv [3];
        rd_vec_t tv;
        Action   w1, w2;

        wv[0] = '{4'h3, 32'hCAFE_BABE, 4'h3, 32'hCAFE_BABE};
        wv[1] = '{4'h0, 32'h0000_0000, 4'h0, 32'h0000_0000};
        wv[2] = '{4'hF, 32'hFFFF_FFFF, 4'hF, 32'hFFFF_FFFF};
        wv[3] = '{4'hA, 32'h1234_5678, 4'hA, 32'h1234_5678};

        rv[0] = '{4'h5, 16'h0000, 8'h2A, 16'h0100, 64'h1122_3344_5566_7788, 3,
                  64'h0100_0008_4A00_0002, 64'h0000_0000_0000_2A28, 64'h1122_3344_5566_7788};
        rv[1] = '{4'hF, 16'hBEEF, 8'h01, 16'hABCD, 64'hDEAD_BEEF_00C0_FFEE, 0,
                  64'hABCD_0008_4A00_0002, 64'h0000_0000_BEEF_0178, 64'hDEAD_BEEF_00C0_FFEE};
        rv[2] = '{4'h0, 16'h1234, 8'hFF, 16'h0000, 64'h0000_0000_0000_0000, 1,
                  64'h0000_0008_4A00_0002, 64'h0000_0000_1234_FF00, 64'h0000_0000_0000_0000};

        // Reset state while reset is held
        repeat (3) @(posedge clk);
        #1;
        check("rst_actready", 64'(actReady), 64'd0);
        check("rst_txvalid", 64'(txValid), 64'd0);
        check("rst_sop_eop", 64'({txSOP, txEOP}), 64'd0);
        check("rst_strobes", 64'({rdReq, wrValid, tmo}), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_actready", 64'(actReady), 64'd1);
        tick();

        // Back-to-back writes, one per cycle
        actValid = 1'b1;
        act = makeAction(ACT_WRITE, wv[0].chan, 16'h0, 8'h0, wv[0].data);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("wr%0d_valid", i), 64'(wrValid), 64'd1);
            check($sformatf("wr%0d_chan", i), 64'(wrChan), 64'(wv[i].exp_chan));
            check($sformatf("wr%0d_data", i), 64'(wrData), 64'(wv[i].exp_data));
            check($sformatf("wr%0d_ready", i), 64'(actReady), 64'd1);
            if (i < 3) act = makeAction(ACT_WRITE, wv[i+1].chan, 16'h0, 8'h0, wv[i+1].data);
        end
        actValid = 1'b0;
        tick();
        check("wr_strobe_single", 64'(wrValid), 64'd0);

        // Reads with txReady held high
        for (int i = 0; i < 3; i++)
            do_read(rv[i], 1'b1, 1'b0, 1'b0, '0, 1'b0, $sformatf("rd%0d", i));

        // Same read with backpressure toggling every cycle
        do_read(rv[0], 1'b1, 1'b1, 1'b0, '0, 1'b0, "stall");

        // No response: all-ones completion plus a timeout pulse
        tv = rv[0];
        tv.b2 = 64'hFFFF_FFFF_FFFF_FFFF;
        do_read(tv, 1'b0, 1'b0, 1'b0, '0, 1'b1, "timeout");

        // Response lands exactly on the timeout cycle: data wins
        tv = rv[0];
        tv.delay = RDT;
        do_read(tv, 1'b1, 1'b0, 1'b0, '0, 1'b0, "race");

        // WRITE, READ, WRITE with actValid held high throughout
        w1 = makeAction(ACT_WRITE, 4'h3, 16'h0, 8'h0, 32'h0000_1111);
        w2 = makeAction(ACT_WRITE, 4'h7, 16'h0, 8'h0, 32'h2222_3333);
        act = w1;
        actValid = 1'b1;
        tick();
        check("strm_w1_valid", 64'(wrValid), 64'd1);
        check("strm_w1_data", 64'(wrData), 64'h0000_1111);
        do_read(rv[1], 1'b1, 1'b0, 1'b1, w2, 1'b0, "strm");
        tick();
        check("strm_w2_valid", 64'(wrValid), 64'd1);
        check("strm_w2_data", 64'(wrData), 64'h2222_3333);
        check("strm_w2_chan", 64'(wrChan), 64'h7);
        actValid = 1'b0;
        tick();
        check("strm_w2_single", 64'(wrValid), 64'd0);

        // Asynchronous reset in the middle of a completion (S_CPL1)
        busid    = rv[0].bus;
        act      = makeAction(ACT_READ, rv[0].chan, rv[0].reqid, rv[0].tag, 32'h0);
        actValid = 1'b1;
        tick();
        actValid = 1'b0;
        rdValid  = 1'b1;
        rdData   = rv[0].data;
        txReady  = 1'b0;
        tick();
        rdValid  = 1'b0;
        check("arst_cpl0_data", txData, rv[0].b0);
        txReady  = 1'b1;
        tick();
        txReady  = 1'b0;
        check("arst_cpl1_data", txData, rv[0].b1);
        #2 rst = 1'b1;
        #1;
        check("arst_txvalid_now", 64'(txValid), 64'd0);
        check("arst_actready_now", 64'(actReady), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        check("arst_release_ready", 64'(actReady), 64'd1);
        check("arst_release_txvalid", 64'(txValid), 64'd0);
        tick();
        do_read(rv[2], 1'b1, 1'b0, 1'b0, '0, 1'b0, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

`default_nettype wire
